// File: rtl/data_memory_if.sv
// Cache <-> data memory block bus. The memError response signal exists only
// when DMEM_RANGE_CHECK_EN is defined.
interface data_memory_if #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128
);
  logic               memRead;
  logic               memWrite;
  logic [ADDR_W-1:0]  memBlockAddr;
  logic [BLOCK_W-1:0] memWriteData;
  logic               memBusywait;
  logic [BLOCK_W-1:0] memReadOut;
`ifdef DMEM_RANGE_CHECK_EN
  logic               memError;

  modport master (output memRead, memWrite, memBlockAddr, memWriteData,
                  input  memBusywait, memReadOut, memError);
  modport slave  (input  memRead, memWrite, memBlockAddr, memWriteData,
                  output memBusywait, memReadOut, memError);
`else
  modport master (output memRead, memWrite, memBlockAddr, memWriteData,
                  input  memBusywait, memReadOut);
  modport slave  (input  memRead, memWrite, memBlockAddr, memWriteData,
                  output memBusywait, memReadOut);
`endif
endinterface

// File: rtl/data_memory_block.sv
// Block-granular data memory serving one fixed-latency line fill or write-back at a time.
// Optional feature macro DMEM_RANGE_CHECK_EN: flags out-of-range block addresses via memError.
module data_memory_block #(
  parameter int BLOCK_W    = 128,
  parameter int ADDR_W     = 28,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  data_memory_if.slave  mem
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   isWrite_q;
  logic [DEPTH_LOG2-1:0]  idx_q;
  logic [BLOCK_W-1:0]     wData_q;
  logic [BLOCK_W-1:0]     readOut_q;
  logic [BLOCK_W-1:0]     memArray_q [2**DEPTH_LOG2];

  logic request;
  logic startAccess;
  logic finishAccess;
  logic rangeErr;

  assign request      = mem.memRead | mem.memWrite;
  assign startAccess  = (state_q == IDLE) && request;
  assign finishAccess = (state_q == BUSY) && (cnt_q == 8'd0);

  // Busywait must react in the same cycle the cache raises its request.
  assign mem.memBusywait = !rst_i && (startAccess || (state_q == BUSY));
  assign mem.memReadOut  = readOut_q;

`ifdef DMEM_RANGE_CHECK_EN
  logic outOfRange_q;
  logic error_q;

  assign rangeErr     = outOfRange_q;
  assign mem.memError = error_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outOfRange_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      if (startAccess)
        outOfRange_q <= |mem.memBlockAddr[ADDR_W-1:DEPTH_LOG2];
      error_q <= finishAccess && outOfRange_q;
    end
  end
`else
  logic unusedUpperBits;

  assign rangeErr        = 1'b0;
  assign unusedUpperBits = ^mem.memBlockAddr[ADDR_W-1:DEPTH_LOG2];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          state_d = BUSY;
          cnt_d   = 8'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0)
          state_d = DONE;
        else
          cnt_d = cnt_q - 8'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured once on entry to BUSY; later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      readOut_q <= '0;
      isWrite_q <= 1'b0;
      idx_q     <= '0;
      wData_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (startAccess) begin
        isWrite_q <= mem.memWrite;
        idx_q     <= mem.memBlockAddr[DEPTH_LOG2-1:0];
        wData_q   <= mem.memWriteData;
      end
      if (finishAccess && !isWrite_q)
        readOut_q <= rangeErr ? '0 : memArray_q[idx_q];
    end
  end

  // Storage has no reset; an access aborted by reset never commits its write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && finishAccess && isWrite_q && !rangeErr)
      memArray_q[idx_q] <= wData_q;
  end
endmodule
